// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop,
// processing one operand bit per clock, LSB first, under start/busy/done.
module serial_adder #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             sum_bit, carry_nxt, last_bit;
    logic             load, finish;

    // Full-adder cell on the current LSBs, and detection of the final bit.
    always_comb begin
        sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
        carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        last_bit  = (cnt == CNT_W'(WIDTH - 1));
    end

    // Next-state logic: accept a request in IDLE, finish on the last bit.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        state_nxt = state;
        load      = 1'b0;
        finish    = 1'b0;
        busy      = (state == RUN);
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset abandons any operation in progress.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand shift registers, carry FF, counter and the result registers.
    always_ff @(posedge clk) begin
        // NOTE: the shift registers are cleared by reset too, so no X can leak
        // into the carry chain or the visible result after power-up.
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            s      <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                // Subtraction is a + ~b + 1: invert B and force the carry-in.
                a_sr  <= a;
                b_sr  <= sub ? ~b : b;
                carry <= sub ? 1'b1 : cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                carry  <= carry_nxt;
                res_sr <= {sum_bit, res_sr[WIDTH-1:1]};
                cnt    <= cnt + CNT_W'(1);
                if (finish) begin
                    // Only the completed word is published; partial sums stay internal.
                    s    <= {sum_bit, res_sr[WIDTH-1:1]};
                    cout <= carry_nxt;
                    ovf  <= carry ^ carry_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH = 8, 2, 16 and 64.
module tb_serial_adder;

    localparam int NDUT   = 4;
    localparam int WV[NDUT] = '{8, 2, 16, 64};

    typedef struct {
        logic [63:0] s;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    logic        start_v[NDUT];
    logic        sub_v[NDUT];
    logic        cin_v[NDUT];
    logic [63:0] a_v[NDUT];
    logic [63:0] b_v[NDUT];
    logic        busy_v[NDUT];
    logic        done_v[NDUT];
    logic [63:0] s_v[NDUT];
    logic        cout_v[NDUT];
    logic        ovf_v[NDUT];

    exp_t        sb_q[NDUT][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic logic [63:0] mask(input int w);
        return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic signed [65:0] sext(input logic [63:0] v, input int w);
        logic signed [65:0] t;
        t = $signed({2'b00, v});
        t = t <<< (66 - w);
        return t >>> (66 - w);
    endfunction

    function automatic exp_t model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                   input logic sub, input logic cin);
        exp_t               e;
        logic [63:0]        m;
        logic [63:0]        a, b;
        logic [64:0]        u;
        logic signed [65:0] r;
        m = mask(w);
        a = a_in & m;
        b = b_in & m;
        if (sub) begin
            u      = {1'b0, a} - {1'b0, b};
            e.cout = (a >= b);
            r      = sext(a, w) - sext(b, w);
        end else begin
            u      = {1'b0, a} + {1'b0, b} + 65'(cin);
            e.cout = u[w];
            r      = sext(a, w) + sext(b, w) + 66'(cin);
        end
        e.s   = u[63:0] & m;
        e.ovf = (r != sext(r[63:0] & m, w));
        e.cyc = 0;
        return e;
    endfunction

    // ---------------- DUTs and per-DUT monitors ----------------
    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
        localparam int W = WV[g];
        logic [W-1:0] s_l;
        logic         busy_l, done_l, cout_l, ovf_l;
        int           bcnt = 0;

        serial_adder #(.WIDTH(W)) dut (
            .clk   (clk),
            .rst   (rst),
            .start (start_v[g]),
            .sub   (sub_v[g]),
            .a     (a_v[g][W-1:0]),
            .b     (b_v[g][W-1:0]),
            .cin   (cin_v[g]),
            .busy  (busy_l),
            .done  (done_l),
            .s     (s_l),
            .cout  (cout_l),
            .ovf   (ovf_l)
        );

        assign busy_v[g] = busy_l;
        assign done_v[g] = done_l;
        assign s_v[g]    = 64'(s_l);
        assign cout_v[g] = cout_l;
        assign ovf_v[g]  = ovf_l;

        // Monitor: pop the expected result whenever done is presented.
        always @(negedge clk) begin
            exp_t e;
            if (busy_l) bcnt++;
            else if (!done_l) bcnt = 0;
            if (done_l) begin
                if (sb_q[g].size() == 0) begin
                    check($sformatf("w%0d_spurious_done", W), 64'(done_l), 64'd0);
                end else begin
                    e = sb_q[g].pop_front();
                    check($sformatf("w%0d_s", W), 64'(s_l), e.s);
                    check($sformatf("w%0d_cout", W), 64'(cout_l), 64'(e.cout));
                    check($sformatf("w%0d_ovf", W), 64'(ovf_l), 64'(e.ovf));
                    check($sformatf("w%0d_latency", W), 64'(cyc - e.cyc), 64'(W));
                    check($sformatf("w%0d_busy_cycles", W), 64'(bcnt), 64'(W));
                end
                bcnt = 0;
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic issue(input int g, input logic [63:0] a, input logic [63:0] b,
                         input logic sub, input logic cin, input bit push);
        exp_t e;
        int   t = 0;
        while (busy_v[g] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy_v[g]) check($sformatf("dut%0d_busy_timeout", g), 64'(busy_v[g]), 64'd0);
        a_v[g]     = a;
        b_v[g]     = b;
        sub_v[g]   = sub;
        cin_v[g]   = cin;
        start_v[g] = 1'b1;
        if (push) begin
            e     = model(WV[g], a, b, sub, cin);
            e.cyc = cyc + 1;
            sb_q[g].push_back(e);
        end
        @(negedge clk);
        start_v[g] = 1'b0;
    endtask

    task automatic wait_done(input int g);
        int t = 0;
        while (!done_v[g] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!done_v[g]) check($sformatf("dut%0d_done_timeout", g), 64'(done_v[g]), 64'd1);
    endtask

    task automatic op(input int g, input logic [63:0] a, input logic [63:0] b,
                      input logic sub, input logic cin);
        issue(g, a, b, sub, cin, 1'b1);
        wait_done(g);
        @(negedge clk);
    endtask

    task automatic rand_run(input int g, input int n);
        logic [63:0] a, b;
        for (int i = 0; i < n; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: a = 64'hFFFF_FFFF_FFFF_FFFF;
                1: b = 64'hFFFF_FFFF_FFFF_FFFF;
                2: b = 64'd0;
                3: b = a;
                default: ;
            endcase
            issue(g, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            wait_done(g);
            // Mostly back-to-back (start in the done cycle), sometimes idle gaps.
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int g = 0; g < NDUT; g++) begin
            start_v[g] = 1'b0;
            sub_v[g]   = 1'b0;
            cin_v[g]   = 1'b0;
            a_v[g]     = '0;
            b_v[g]     = '0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("dut%0d_rst_busy", g), 64'(busy_v[g]), 64'd0);
            check($sformatf("dut%0d_rst_done", g), 64'(done_v[g]), 64'd0);
            check($sformatf("dut%0d_rst_s", g), s_v[g], 64'd0);
        end
        check("rst_cout", 64'(cout_v[0]), 64'd0);
        check("rst_ovf", 64'(ovf_v[0]), 64'd0);
        @(negedge clk);

        // Directed add, wrap and subtract cases at WIDTH=8
        op(0, 64'h5A, 64'h33, 1'b0, 1'b0);
        op(0, 64'hFF, 64'h01, 1'b0, 1'b0);
        op(0, 64'h7F, 64'h00, 1'b0, 1'b1);
        op(0, 64'h10, 64'h20, 1'b1, 1'b1);
        op(0, 64'h80, 64'h01, 1'b1, 1'b0);

        // Start and operand changes while busy are ignored
        issue(0, 64'h12, 64'h34, 1'b0, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        a_v[0]     = 64'hAA;
        b_v[0]     = 64'h55;
        sub_v[0]   = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0);
        // Start during the done cycle is accepted
        issue(0, 64'h3C, 64'h0F, 1'b1, 1'b0, 1'b1);
        wait_done(0);
        @(negedge clk);

        // Reset mid-operation: abandoned, no done, outputs cleared
        issue(0, 64'hC3, 64'h5A, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(busy_v[0]), 64'd0);
        check("midrst_done", 64'(done_v[0]), 64'd0);
        check("midrst_s", s_v[0], 64'd0);
        check("midrst_cout", 64'(cout_v[0]), 64'd0);
        check("midrst_ovf", 64'(ovf_v[0]), 64'd0);
        repeat (10) @(negedge clk);
        check("midrst_no_done", 64'(done_v[0]), 64'd0);
        op(0, 64'h01, 64'h01, 1'b0, 1'b0);

        // Randomised sweep on all widths in parallel
        fork
            rand_run(0, 200);
            rand_run(1, 500);
            rand_run(2, 500);
            rand_run(3, 500);
        join

        repeat (4) @(negedge clk);
        for (int g = 0; g < NDUT; g++)
            check($sformatf("dut%0d_pending_results", g), 64'(sb_q[g].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
